// File: rtl/alu_uart_sequencer.sv
// rtl/alu_uart_sequencer.sv - UART packet sequencer driving ALU register writes, execute and result return
module alu_uart_sequencer #(
  parameter int EXEC_LAT = 2,
  parameter int TIMEOUT  = 1200000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [5:0]  alu_op,
  output logic [3:0]  alu_params,
  output logic [2:0]  alu_a,
  output logic [2:0]  alu_b,
  output logic [2:0]  alu_y,
  output logic        alu_wr_en,
  output logic [2:0]  alu_wr_idx,
  output logic [15:0] alu_wr_data,
  output logic        alu_exec,
  input  logic [15:0] alu_result,
  input  logic        alu_overflow,
  output logic        busy,
  output logic        err
);

  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_R1   = 5'd1;
  localparam logic [4:0] S_R2   = 5'd2;
  localparam logic [4:0] S_R3   = 5'd3;
  localparam logic [4:0] S_R4   = 5'd4;
  localparam logic [4:0] S_R5   = 5'd5;
  localparam logic [4:0] S_R6   = 5'd6;
  localparam logic [4:0] S_R7   = 5'd7;
  localparam logic [4:0] S_WR_A = 5'd8;
  localparam logic [4:0] S_WR_B = 5'd9;
  localparam logic [4:0] S_EXEC = 5'd10;
  localparam logic [4:0] S_WAIT = 5'd11;
  localparam logic [4:0] S_TX0  = 5'd12;
  localparam logic [4:0] S_TX0G = 5'd13;
  localparam logic [4:0] S_TX1  = 5'd14;
  localparam logic [4:0] S_TX1G = 5'd15;
  localparam logic [4:0] S_TX2  = 5'd16;
  localparam logic [4:0] S_TX2G = 5'd17;

  localparam logic [23:0] TO_LAST  = 24'(TIMEOUT - 1);
  localparam logic [3:0]  LAT_LAST = 4'(EXEC_LAT - 1);

  logic [4:0]  r_state;
  logic [5:0]  r_op;
  logic [3:0]  r_params;
  logic [2:0]  r_a;
  logic [2:0]  r_b;
  logic [2:0]  r_y;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [15:0] r_res;
  logic        r_ovf;
  logic [3:0]  r_wait;
  logic [23:0] r_to_cnt;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;

  logic        w_in_rx;
  logic        w_hdr_ok;
  logic        w_timeout;
  logic [4:0]  w_rx_next;
  logic [7:0]  w_tx_byte;

  assign w_in_rx   = (r_state >= S_R1) && (r_state <= S_R7);
  assign w_hdr_ok  = (rx_data[7:6] == 2'b10);
  // A byte arriving in the expiry cycle takes priority over the abort.
  assign w_timeout = w_in_rx && !rx_ready && (r_to_cnt == TO_LAST);
  assign w_rx_next = (r_state == S_R7) ? S_WR_A : r_state + 5'd1;

  always_comb begin
    w_tx_byte = {7'd0, r_ovf};
    case (r_state)
      S_TX0:   w_tx_byte = r_res[7:0];
      S_TX1:   w_tx_byte = r_res[15:8];
      default: w_tx_byte = {7'd0, r_ovf};
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op     <= '0;
      r_params <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
    end else if (rx_ready) begin
      case (r_state)
        S_IDLE: if (w_hdr_ok) r_op <= rx_data[5:0];
        S_R1:   r_params <= rx_data[3:0];
        S_R2: begin
          r_a <= rx_data[6:4];
          r_b <= rx_data[2:0];
        end
        S_R3:   r_y <= rx_data[2:0];
        S_R4:   r_opa[7:0]  <= rx_data;
        S_R5:   r_opa[15:8] <= rx_data;
        S_R6:   r_opb[7:0]  <= rx_data;
        S_R7:   r_opb[15:8] <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_res      <= '0;
      r_ovf      <= 1'b0;
      r_wait     <= '0;
      r_to_cnt   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_ready && w_hdr_ok) begin
            r_to_cnt <= '0;
            r_state  <= S_R1;
          end
        end
        S_R1, S_R2, S_R3, S_R4, S_R5, S_R6, S_R7: begin
          if (rx_ready) begin
            r_to_cnt <= '0;
            r_state  <= w_rx_next;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 24'd1;
          end
        end
        S_WR_A: r_state <= S_WR_B;
        S_WR_B: r_state <= S_EXEC;
        S_EXEC: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == LAT_LAST) begin
            r_res   <= alu_result;
            r_ovf   <= alu_overflow;
            r_state <= S_TX0;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_TX0, S_TX1, S_TX2: begin
          if (!tx_busy) begin
            r_tx_data  <= w_tx_byte;
            r_tx_start <= 1'b1;
            r_state    <= r_state + 5'd1;
          end
        end
        // Guard cycle: the UART raises busy one cycle after tx_start.
        S_TX0G, S_TX1G: r_state <= r_state + 5'd1;
        S_TX2G:         r_state <= S_IDLE;
        default:        r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign alu_op      = r_op;
  assign alu_params  = r_params;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_y       = r_y;
  assign alu_wr_en   = (r_state == S_WR_A) || (r_state == S_WR_B);
  assign alu_wr_idx  = (r_state == S_WR_B) ? r_b : ((r_state == S_WR_A) ? r_a : 3'd0);
  assign alu_wr_data = (r_state == S_WR_B) ? r_opb : ((r_state == S_WR_A) ? r_opa : 16'd0);
  assign alu_exec    = (r_state == S_EXEC);
  assign busy        = (r_state != S_IDLE);
  assign err         = w_timeout;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb/tb_alu_uart_sequencer.sv - randomized self-checking bench for alu_uart_sequencer
module tb_alu_uart_sequencer;

  localparam int EXEC_LAT = 3;
  localparam int TIMEOUT  = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [5:0]  alu_op;
  logic [3:0]  alu_params;
  logic [2:0]  alu_a;
  logic [2:0]  alu_b;
  logic [2:0]  alu_y;
  logic        alu_wr_en;
  logic [2:0]  alu_wr_idx;
  logic [15:0] alu_wr_data;
  logic        alu_exec;
  logic [15:0] alu_result = 16'd0;
  logic        alu_overflow = 1'b0;
  logic        busy;
  logic        err;

  alu_uart_sequencer #(.EXEC_LAT(EXEC_LAT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .alu_op(alu_op), .alu_params(alu_params), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_wr_en(alu_wr_en), .alu_wr_idx(alu_wr_idx), .alu_wr_data(alu_wr_data),
    .alu_exec(alu_exec), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errs   = 0;

  int cyc = 0, last_rx_cyc = 0, exec_cyc = 0, exec_lat = 0, first_tx_lat = 0, err_cyc = 0;
  int exec_cnt = 0, err_cnt = 0, viol = 0;
  int lat_k = 0, uart_len = 0, busy_cnt = 0;
  bit pend = 0, hold_busy = 0, prev_start = 0;
  logic [16:0] pend_val;
  logic [18:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] alu_regs[8];
  logic [15:0] ref_regs[8];

  logic [5:0]  exp_op;
  logic [3:0]  exp_par;
  logic [2:0]  exp_a, exp_b, exp_y;
  logic [15:0] exp_va, exp_vb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observer plus stand-in ALU (add with carry-out overflow) and UART transmitter.
  always @(negedge CLK) begin
    cyc++;
    if (rx_ready) last_rx_cyc = cyc;
    if (alu_wr_en && alu_exec) viol++;
    if (tx_start && prev_start) viol++;
    if (tx_start && tx_busy) viol++;
    prev_start = tx_start;
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (alu_wr_en) begin
      alu_regs[alu_wr_idx] = alu_wr_data;
      wr_q.push_back({alu_wr_idx, alu_wr_data});
    end
    if (alu_exec) begin
      exec_cnt++;
      exec_cyc = cyc;
      exec_lat = cyc - last_rx_cyc;
      pend = 1;
      lat_k = EXEC_LAT;
      pend_val = {1'b0, alu_regs[alu_a]} + {1'b0, alu_regs[alu_b]};
    end else if (lat_k > 0) begin
      lat_k--;
    end
    if (pend && lat_k == 0) begin
      alu_result = pend_val[15:0];
      alu_overflow = pend_val[16];
      pend = 0;
    end else begin
      alu_result = 16'($urandom);
      alu_overflow = 1'($urandom);
    end
    if (tx_start) begin
      if (tx_q.size() == 0) first_tx_lat = cyc - exec_cyc;
      tx_q.push_back(tx_data);
      busy_cnt = uart_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = hold_busy || (busy_cnt > 0);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge CLK); #1;
    rx_data = b;
    rx_ready = 1'b1;
    @(posedge CLK); #1;
    rx_ready = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) @(posedge CLK);
  endtask

  task automatic send_pkt(input logic [5:0] op, input logic [3:0] par, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] y, input logic [15:0] va,
                          input logic [15:0] vb, input int maxgap, input int nbytes);
    logic [7:0] pk [8];
    wr_q.delete(); tx_q.delete();
    exec_cnt = 0; err_cnt = 0; viol = 0;
    exp_op = op; exp_par = par; exp_a = a; exp_b = b; exp_y = y; exp_va = va; exp_vb = vb;
    pk[0] = {2'b10, op};
    pk[1] = {4'($urandom), par};
    pk[2] = {1'($urandom), a, 1'($urandom), b};
    pk[3] = {5'($urandom), y};
    pk[4] = va[7:0];
    pk[5] = va[15:8];
    pk[6] = vb[7:0];
    pk[7] = vb[15:8];
    for (int i = 0; i < nbytes; i++) send_byte(pk[i], $urandom_range(maxgap, 0));
  endtask

  task automatic finish_pkt(input string tag, input bit chk_tx_lat);
    logic [16:0] sum;
    logic [63:0] got_w, got_t;
    ref_regs[exp_a] = exp_va;
    ref_regs[exp_b] = exp_vb;
    sum = {1'b0, ref_regs[exp_a]} + {1'b0, ref_regs[exp_b]};
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!busy) break;
    end
    check({tag, "_done"}, busy, 0);
    got_w = (wr_q.size() == 2) ? {26'd0, wr_q[0], wr_q[1]} : 64'hDEAD;
    check({tag, "_writes"}, got_w, {26'd0, exp_a, exp_va, exp_b, exp_vb});
    check({tag, "_exec_cnt"}, exec_cnt, 1);
    check({tag, "_exec_lat"}, exec_lat, 3);
    got_t = (tx_q.size() == 3) ? {40'd0, tx_q[2], tx_q[1], tx_q[0]} : 64'hDEAD;
    check({tag, "_tx"}, got_t, {40'd0, 7'd0, sum[16], sum[15:8], sum[7:0]});
    check({tag, "_cfg"}, {alu_op, alu_params, alu_a, alu_b, alu_y},
          {exp_op, exp_par, exp_a, exp_b, exp_y});
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_proto"}, viol, 0);
    if (chk_tx_lat) check({tag, "_tx_lat"}, first_tx_lat, EXEC_LAT + 2);
  endtask

  function automatic logic [63:0] all_outs();
    return {13'd0, tx_data, tx_start, alu_op, alu_params, alu_a, alu_b, alu_y,
            alu_wr_en, alu_wr_idx, alu_wr_data, alu_exec, busy, err};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin alu_regs[i] = 16'd0; ref_regs[i] = 16'd0; end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outs", all_outs(), 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    send_pkt(6'h01, 4'h3, 3'd2, 3'd1, 3'd5, 16'h1234, 16'h5678, 0, 8);
    finish_pkt("nominal", 1);

    send_pkt(6'($urandom), 4'($urandom), 3'd3, 3'd3, 3'd0, 16'h1111, 16'h2222, 3, 8);
    finish_pkt("same_idx", 1);

    send_byte(8'h00, 2);
    send_byte(8'h7F, 2);
    @(negedge CLK);
    check("resync_idle", busy, 0);
    send_pkt(6'h2A, 4'h9, 3'd4, 3'd6, 3'd7, 16'hFFFF, 16'h0002, 2, 8);
    finish_pkt("resync", 1);

    send_pkt(6'h05, 4'h1, 3'd1, 3'd2, 3'd3, 16'hAAAA, 16'h5555, 0, 3);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (err_cnt > 0) break;
    end
    check("to_err_cnt", err_cnt, 1);
    check("to_err_cyc", err_cyc - last_rx_cyc, TIMEOUT);
    @(negedge CLK);
    check("to_busy", busy, 0);
    repeat (10) @(negedge CLK);
    check("to_no_alu", {wr_q.size(), exec_cnt}, 0);

    hold_busy = 1;
    send_pkt(6'h11, 4'h7, 3'd5, 3'd0, 3'd2, 16'hBEEF, 16'h4321, 1, 8);
    repeat (50) @(posedge CLK);
    check("bp_no_start", tx_q.size(), 0);
    send_byte(8'h85, 0);
    #1;
    check("bp_busy", busy, 1);
    hold_busy = 0;
    finish_pkt("bp", 0);

    send_pkt(6'h3F, 4'hF, 3'd7, 3'd6, 3'd1, 16'h0F0F, 16'hF0F0, 0, 4);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    check("rst_mid_outs", all_outs(), 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    send_pkt(6'h21, 4'h2, 3'd0, 3'd7, 3'd4, 16'h8000, 16'h8001, 2, 8);
    finish_pkt("after_rst", 1);

    for (int n = 0; n < 20; n++) begin
      logic [2:0] ra, rb;
      uart_len = $urandom_range(4, 0);
      ra = 3'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? ra : 3'($urandom);
      send_pkt(6'($urandom), 4'($urandom), ra, rb, 3'($urandom),
               16'($urandom), 16'($urandom), 10, 8);
      finish_pkt($sformatf("rand%0d", n), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
